// File: rtl/uart_pkg.sv
// UART shared definitions: frame layout and receiver FSM state codes.
// Used by both uart_rx and uart_tx.
package uart_pkg;

  localparam int   DATA_BITS  = 8;
  localparam int   FRAME_BITS = 11;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t S_IDLE   = 3'd0;
  localparam uart_state_t S_START  = 3'd1;
  localparam uart_state_t S_DATA   = 3'd2;
  localparam uart_state_t S_PARITY = 3'd3;
  localparam uart_state_t S_STOP   = 3'd4;
  localparam uart_state_t S_BREAK  = 3'd5;

endpackage

// File: rtl/uart_rx_sync.sv
// UART rx line synchronizer.
// Flops reset to the idle level so reset never looks like a start bit.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_s
);

  logic [SYNC_STAGES-1:0] ff;

  // shift the raw line through the flop chain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ff <= '1;
    else        ff <= {ff[SYNC_STAGES-2:0], rx};
  end

  assign rx_s = ff[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, even parity, 1 stop bit.
// Midpoint sampling with a one-entry valid/ack output buffer.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int MID = (CLKS_PER_BIT - 1) / 2;
  localparam int CW  =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CW-1:0] MID_C = CW'(MID);
  localparam logic [CW-1:0] END_C = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  uart_state_t   state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          perr;
  logic          rx_s;
  logic          mid;
  logic          bend;
  logic          done;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .rx   (rx),
    .rx_s (rx_s)
  );

  assign mid     = (baud_cnt == MID_C);
  assign bend    = (baud_cnt == END_C);
  assign done    = (state == S_STOP) && mid;
  assign rx_busy = (state != S_IDLE);

  // frame FSM; the IDLE cycle that sees the start edge is bit cycle 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      perr     <= 1'b0;
    end else begin
      baud_cnt <= bend ? '0 : baud_cnt + ONE_C;
      case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (!rx_s) begin
            if (CLKS_PER_BIT == 1) begin
              state <= S_DATA;
            end else begin
              state    <= S_START;
              baud_cnt <= ONE_C;
            end
          end
        end
        S_START: begin
          if (mid && rx_s) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
          end else if (bend) begin
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (mid) shift[bit_idx] <= rx_s;
          if (bend) begin
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= S_PARITY;
          end
        end
        S_PARITY: begin
          if (mid)  perr  <= rx_s ^ (^shift);
          if (bend) state <= S_STOP;
        end
        S_STOP: begin
          if (mid) begin
            state    <= rx_s ? S_IDLE : S_BREAK;
            baud_cnt <= '0;
          end
        end
        S_BREAK: begin
          baud_cnt <= '0;
          if (rx_s) state <= S_IDLE;
        end
        default: begin
          state    <= S_IDLE;
          baud_cnt <= '0;
        end
      endcase
    end
  end

  // one-entry output buffer; a completion with ack pending replaces it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out   <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!rx_valid || rx_ack) begin
          data_out   <= shift;
          parity_err <= perr;
          frame_err  <= ~rx_s;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: table-driven frames plus corner-case sequences.
// Instance 0 runs at 16 clocks/bit, instance 1 at 1 clock/bit.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_l  [2];
  logic       ack_l [2];
  logic [7:0] dout  [2];
  logic       vld   [2];
  logic       perr  [2];
  logic       ferr  [2];
  logic       ovr   [2];
  logic       busy  [2];

  int n_chk  = 0;
  int n_fail = 0;

  int unsigned cyc = 0;
  int vrise [2];
  int vfall [2];
  int ovr_n [2];
  int rise_cyc [2];
  bit vq [2];

  typedef struct {
    logic [7:0] d;
    logic       pbit;
    logic       sbit;
    logic [7:0] ed;
    logic       eperr;
    logic       eferr;
  } vec_t;

  vec_t vt[$];

  uart_rx #(.CLKS_PER_BIT(16), .SYNC_STAGES(2)) u_rx16 (
    .clk(clk), .reset(reset), .rx(rx_l[0]), .rx_ack(ack_l[0]),
    .data_out(dout[0]), .rx_valid(vld[0]), .parity_err(perr[0]),
    .frame_err(ferr[0]), .overrun(ovr[0]), .rx_busy(busy[0])
  );

  uart_rx #(.CLKS_PER_BIT(1), .SYNC_STAGES(2)) u_rx1 (
    .clk(clk), .reset(reset), .rx(rx_l[1]), .rx_ack(ack_l[1]),
    .data_out(dout[1]), .rx_valid(vld[1]), .parity_err(perr[1]),
    .frame_err(ferr[1]), .overrun(ovr[1]), .rx_busy(busy[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (vld[i] === 1'b1 && !vq[i]) begin
        vrise[i]++;
        rise_cyc[i] = cyc;
      end
      if (vld[i] !== 1'b1 && vq[i]) vfall[i]++;
      if (ovr[i] === 1'b1) ovr_n[i]++;
      vq[i] = (vld[i] === 1'b1);
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bits(input int i, input int cpb,
                           input logic [10:0] fr, input int nb);
    for (int b = 0; b < nb; b++) begin
      rx_l[i] = fr[b];
      tick(cpb);
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] d,
                                        input logic p,
                                        input logic s);
    return {s, p, d, 1'b0};
  endfunction

  task automatic do_ack(input int i, input string nm);
    ack_l[i] = 1'b1;
    tick(1);
    ack_l[i] = 1'b0;
    @(negedge clk);
    chk({nm, " valid after ack"}, 32'(vld[i]), 32'd0);
  endtask

  task automatic chk_out(input int i, input string nm,
                         input logic [7:0] d, input logic pe,
                         input logic fe);
    chk({nm, " valid"},  32'(vld[i]),  32'd1);
    chk({nm, " data"},   32'(dout[i]), 32'(d));
    chk({nm, " perr"},   32'(perr[i]), 32'(pe));
    chk({nm, " ferr"},   32'(ferr[i]), 32'(fe));
  endtask

  // reference: even parity over data plus parity bit, stop must be 1
  function automatic vec_t model(input logic [7:0] d,
                                 input logic p, input logic s);
    vec_t v;
    v.d     = d;
    v.pbit  = p;
    v.sbit  = s;
    v.ed    = d;
    v.eperr = ($countones({p, d}) % 2) == 1;
    v.eferr = (s == 1'b0);
    return v;
  endfunction

  initial begin
    int r0, f0, o0, p;
    logic [7:0] d;
    logic pb, sb;

    rx_l[0] = 1'b1; rx_l[1] = 1'b1;
    ack_l[0] = 1'b0; ack_l[1] = 1'b0;

    vt.push_back('{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0});
    vt.push_back('{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0});
    vt.push_back('{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1});
    vt.push_back('{8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0});
    for (int k = 0; k < 8; k++) begin
      d  = 8'($urandom);
      pb = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
      sb = ($urandom_range(0, 4) == 0) ? 1'b0 : 1'b1;
      vt.push_back(model(d, pb, sb));
    end

    tick(3);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset valid", 32'(vld[i]),  32'd0);
      chk("reset data",  32'(dout[i]), 32'd0);
      chk("reset busy",  32'(busy[i]), 32'd0);
      chk("reset ovr",   32'(ovr[i]),  32'd0);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    tick(5);

    foreach (vt[k]) begin
      r0 = vrise[0];
      p  = int'(cyc);
      send_bits(0, 16, frame(vt[k].d, vt[k].pbit, vt[k].sbit), 11);
      if (!vt[k].sbit) begin
        rx_l[0] = 1'b0;
        tick(40);
      end
      rx_l[0] = 1'b1;
      tick(20);
      @(negedge clk);
      chk_out(0, $sformatf("vec%0d", k), vt[k].ed, vt[k].eperr,
              vt[k].eferr);
      chk("one frame reported", 32'(vrise[0] - r0), 32'd1);
      chk("busy after frame", 32'(busy[0]), 32'd0);
      if (k == 0)
        chk("latency", 32'(rise_cyc[0] - p), 32'd170);
      do_ack(0, "vec");
    end

    r0 = vrise[0];
    rx_l[0] = 1'b0;
    tick(4);
    rx_l[0] = 1'b1;
    @(negedge clk);
    chk("glitch busy", 32'(busy[0]), 32'd1);
    tick(12);
    @(negedge clk);
    chk("glitch idle", 32'(busy[0]), 32'd0);
    chk("glitch no frame", 32'(vrise[0] - r0), 32'd0);

    o0 = ovr_n[0];
    send_bits(0, 16, frame(8'h11, 1'b0, 1'b1), 11);
    send_bits(0, 16, frame(8'h22, 1'b0, 1'b1), 11);
    rx_l[0] = 1'b1;
    tick(20);
    @(negedge clk);
    chk("overrun keep data", 32'(dout[0]), 32'h11);
    chk("overrun valid", 32'(vld[0]), 32'd1);
    chk("overrun pulse", 32'(ovr_n[0] - o0), 32'd1);
    do_ack(0, "overrun");

    o0 = ovr_n[0];
    send_bits(0, 16, frame(8'h11, 1'b0, 1'b1), 11);
    f0 = vfall[0];
    p  = int'(cyc);
    fork
      send_bits(0, 16, frame(8'h22, 1'b0, 1'b1), 11);
      begin
        tick(169);
        ack_l[0] = 1'b1;
        tick(1);
        ack_l[0] = 1'b0;
      end
    join
    rx_l[0] = 1'b1;
    tick(20);
    @(negedge clk);
    chk("ack replace data", 32'(dout[0]), 32'h22);
    chk("ack replace valid", 32'(vld[0]), 32'd1);
    chk("ack replace no drop", 32'(vfall[0] - f0), 32'd0);
    chk("ack replace no ovr", 32'(ovr_n[0] - o0), 32'd0);
    do_ack(0, "replace");

    for (int k = 0; k < 3; k++) begin
      d = (k == 0) ? 8'h00 : (k == 1) ? 8'hFF : 8'h80;
      send_bits(1, 1, frame(d, ^d, 1'b1), 11);
      rx_l[1] = 1'b1;
      tick(4);
      @(negedge clk);
      chk_out(1, $sformatf("fast%0d", k), d, 1'b0, 1'b0);
      if (k < 2) do_ack(1, "fast");
    end

    send_bits(1, 1, frame(8'hC3, 1'b0, 1'b1), 5);
    @(negedge clk);
    chk("mid frame busy", 32'(busy[1]), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async rst valid", 32'(vld[1]),  32'd0);
    chk("async rst data",  32'(dout[1]), 32'd0);
    chk("async rst busy",  32'(busy[1]), 32'd0);
    chk("async rst perr",  32'(perr[1]), 32'd0);
    chk("async rst ferr",  32'(ferr[1]), 32'd0);
    chk("async rst ovr",   32'(ovr[1]),  32'd0);
    rx_l[1] = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(3);
    send_bits(1, 1, frame(8'hC3, 1'b0, 1'b1), 11);
    rx_l[1] = 1'b1;
    tick(4);
    @(negedge clk);
    chk_out(1, "post reset", 8'hC3, 1'b0, 1'b0);
    do_ack(1, "post reset");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
